// File: rtl/dispatch_scheduler.sv
// Dispatch-stage sequencer: gates decoder-to-dispatcher handoff, allocates ROB tags and
// tracks ROB/RS/LSB occupancy, with a fixed-length FLUSH window after a mispredict.
module dispatch_scheduler #(
    parameter int ROB_W     = 4,
    parameter int RS_DEPTH  = 16,
    parameter int LSB_DEPTH = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             dec_valid_in,
    input  logic             dec_is_mem_in,
    output logic             sched_dec_ready_out,
    output logic             sched_disp_en_out,
    output logic [ROB_W-1:0] sched_rob_tag_out,
    output logic [ROB_W-1:0] sched_rob_head_out,
    input  logic             rob_commit_en_in,
    input  logic             rs_free_en_in,
    input  logic             lsb_free_en_in,
    input  logic             rob_flush_in,
    output logic [31:0]      sched_stall_cnt_out,
    output logic             sched_err_out
);
    localparam int ROB_N  = 2**ROB_W - 1;
    localparam int RS_CW  = $clog2(RS_DEPTH + 1);
    localparam int LSB_CW = $clog2(LSB_DEPTH + 1);
    localparam int FC_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t            r_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [ROB_W-1:0]  r_head, r_tail, r_rob_cnt;
    logic [RS_CW-1:0]  r_rs_cnt;
    logic [LSB_CW-1:0] r_lsb_cnt;
    logic [31:0]       r_stall;
    logic              r_err;

    logic w_run, w_ready, w_fire;
    logic w_rob_dec, w_rs_inc, w_rs_dec, w_lsb_inc, w_lsb_dec, w_underflow;

    // Tag 0 means "no dependency", so pointers cycle 1..ROB_N.
    function automatic logic [ROB_W-1:0] f_next(input logic [ROB_W-1:0] p);
        return (p == ROB_W'(ROB_N)) ? ROB_W'(1) : p + ROB_W'(1);
    endfunction

    assign w_run   = (r_state == S_RUN);
    assign w_ready = !rst_in && rdy_in && w_run && !rob_flush_in
                     && (r_rob_cnt < ROB_W'(ROB_N))
                     && ((r_rs_cnt  < RS_CW'(RS_DEPTH))   || dec_is_mem_in)
                     && ((r_lsb_cnt < LSB_CW'(LSB_DEPTH)) || !dec_is_mem_in);
    assign w_fire  = w_ready && dec_valid_in;

    assign w_rob_dec   = rob_commit_en_in && (r_rob_cnt != '0);
    assign w_rs_inc    = w_fire && !dec_is_mem_in;
    assign w_rs_dec    = rs_free_en_in && (r_rs_cnt != '0);
    assign w_lsb_inc   = w_fire && dec_is_mem_in;
    assign w_lsb_dec   = lsb_free_en_in && (r_lsb_cnt != '0);
    assign w_underflow = (rob_commit_en_in && (r_rob_cnt == '0))
                      || (rs_free_en_in && (r_rs_cnt == '0))
                      || (lsb_free_en_in && (r_lsb_cnt == '0));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
            r_head      <= ROB_W'(1);
            r_tail      <= ROB_W'(1);
            r_rob_cnt   <= '0;
            r_rs_cnt    <= '0;
            r_lsb_cnt   <= '0;
            r_stall     <= '0;
            r_err       <= 1'b0;
        end else if (rdy_in) begin
            if (w_run && dec_valid_in && !w_fire)
                r_stall <= r_stall + 32'd1;
            if (rob_flush_in) begin
                r_state     <= S_FLUSH;
                r_flush_cnt <= FC_LOAD;
                r_head      <= ROB_W'(1);
                r_tail      <= ROB_W'(1);
                r_rob_cnt   <= '0;
                r_rs_cnt    <= '0;
                r_lsb_cnt   <= '0;
            end else if (!w_run) begin
                // Releases are stale after a flush and are dropped here.
                if (r_flush_cnt == '0) r_state <= S_RUN;
                else                   r_flush_cnt <= r_flush_cnt - 1'b1;
            end else begin
                if (w_fire)    r_tail <= f_next(r_tail);
                if (w_rob_dec) r_head <= f_next(r_head);
                r_rob_cnt <= r_rob_cnt + ROB_W'(w_fire) - ROB_W'(w_rob_dec);
                r_rs_cnt  <= r_rs_cnt + RS_CW'(w_rs_inc) - RS_CW'(w_rs_dec);
                r_lsb_cnt <= r_lsb_cnt + LSB_CW'(w_lsb_inc) - LSB_CW'(w_lsb_dec);
                if (w_underflow) r_err <= 1'b1;
            end
        end
    end

    assign sched_dec_ready_out = w_ready;
    assign sched_disp_en_out   = w_fire;
    assign sched_rob_tag_out   = rst_in ? '0 : r_tail;
    assign sched_rob_head_out  = rst_in ? '0 : r_head;
    assign sched_stall_cnt_out = rst_in ? '0 : r_stall;
    assign sched_err_out       = rst_in ? 1'b0 : r_err;
endmodule
